change_logger: RTL
==================

// Module: change_logger
// PURPOSE
//  Downstream consumer of the Device 4-bit data output. Watches the data bus every cycle
//  and records a timestamped entry each time the value changes. Entries are buffered in
//  a small FIFO and drained over a valid/ready stream toward a debug/trace sink.
// PARAMETERS
//  DATA_WIDTH  4   width of the observed data bus
//  TS_WIDTH    12  timestamp counter width; wraps modulo 2**TS_WIDTH
//  DEPTH       8   FIFO entries; must be a power of 2 and at least 2
// PORTS
//  clock      in   1                     sole clock; all logic on posedge
//  clear      in   1                     synchronous, active-high reset
//  enable     in   1                     1 = observe and timestamp; 0 = freeze capture
//  data       in   DATA_WIDTH            observed bus, sampled every posedge
//  out_valid  out  1                     FIFO holds at least one record
//  out_ready  in   1                     sink accepts head record this cycle
//  out_ts     out  TS_WIDTH              timestamp of head record
//  out_data   out  DATA_WIDTH            data value of head record
//  level      out  $clog2(DEPTH+1)       entries currently stored, 0..DEPTH
//  overflow   out  1                     sticky: at least one record dropped
//  dropped    out  8                     dropped-record count; saturates at 255
// BEHAVIOUR
//  - clear has priority over everything. It zeroes ts, prev, primed, FIFO pointers,
//    level, overflow and dropped, and drives out_valid=0. Pending records are discarded.
//    A clear asserted mid-stream behaves the same: out_valid is 0 the next cycle.
//  - Timestamp counter ts:
//    - +1 each cycle while enable=1; holds while enable=0.
//    - Wraps to 0 after the all-ones value; no marker is recorded on wrap.
//  - Event detection (enable=1 only):
//    - event = !primed || (data != prev). The first enabled cycle after clear always
//      logs the initial value and sets primed=1.
//    - prev <= data on every enabled cycle.
//    - Record = {ts (pre-increment value), data}.
//  - enable=0: no events; prev, primed and ts hold. The FIFO still drains normally.
//  - Push rule: event is accepted if !full, OR if full and a pop happens the same cycle
//    (out_valid && out_ready). Otherwise the record is dropped, overflow<=1 and dropped
//    increments (saturating at 255).
//  - Simultaneous push and pop leave level unchanged; ordering is strictly FIFO.
//  - Latency: a change sampled at edge N appears at the head no earlier than cycle N+1.
//    An empty FIFO shows out_valid=1 right after edge N.
//  - Handshake: pop when out_valid && out_ready. out_ts and out_data are stable while
//    out_valid && !out_ready. out_ready is ignored when empty.
//    out_valid = (level != 0). Outputs are combinational reads of registered storage.
//  - overflow and dropped clear only on clear.
//  - No state machine beyond the primed flag. The FIFO uses wrap-around pointers with an
//    extra MSB to distinguish full from empty.
// STRUCTURE
//  - Package logger_pkg holds the typedef record_t (struct packed {ts, data}) and the
//    defaults for TS_WIDTH, DEPTH and DROP_CNT_WIDTH=8.
//  - Sub-module sync_fifo (parameters WIDTH, DEPTH):
//    - Ports: clock, clear, push, din, full, pop, dout, empty, level.
//    - Supports push while full when pop is asserted in the same cycle.
//  - The top level contains ts, prev, primed, the event/push logic and the drop counters.
// TESTING
//  1. clear, then enable=1, data=4'h0 held, out_ready=0 -> exactly one record {ts=0,data=0};
//     out_valid=1 one cycle later; level stays 1.
//  2. data 0,0,0,5,5,A from ts=0 -> records {0,0},{3,5},{5,A}; repeated values log nothing.
//  3. DEPTH=8, out_ready=0, 9 distinct changes -> level=8, overflow=1, dropped=1. Then
//     out_ready=1 drains 8 records in order, oldest first.
//  4. FIFO full, out_ready=1 and a change in the same cycle -> record accepted, level
//     stays 8, overflow stays 0.
//  5. enable=0 for 5 cycles while data toggles -> no records and ts frozen. On re-enable,
//     a differing value logs with the held ts.
//  6. clear asserted with level=3 and overflow=1 -> next cycle out_valid=0, level=0,
//     overflow=0, dropped=0, ts=0; the first enabled cycle logs the initial value.
//  7. TS_WIDTH=4, constant data, change at cycle 17 -> record ts=1 (wrapped).
//  8. dropped saturation: 300 drops -> dropped=255.

Source files
------------

// File: rtl/logger_pkg.sv
// Shared types and default sizing for the change logger and its record FIFO.
package logger_pkg;

  localparam int DATA_WIDTH_DEF = 4;
  localparam int TS_WIDTH_DEF   = 12;
  localparam int DEPTH_DEF      = 8;
  localparam int DROP_CNT_WIDTH = 8;

  typedef struct packed {
    logic [TS_WIDTH_DEF-1:0]   ts;
    logic [DATA_WIDTH_DEF-1:0] data;
  } record_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; accepts a push while full if a pop
// happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = LW'(wptr - rptr);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/change_logger.sv
// Timestamps every change on an observed bus and streams the records out of a
// small FIFO over valid/ready, counting any records that could not be stored.
module change_logger
  import logger_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TS_WIDTH   = TS_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic                       enable,
  input  logic [DATA_WIDTH-1:0]      data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [TS_WIDTH-1:0]        out_ts,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic [DROP_CNT_WIDTH-1:0]  dropped
);

  typedef struct packed {
    logic [TS_WIDTH-1:0]   ts;
    logic [DATA_WIDTH-1:0] data;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(
    input logic [DROP_CNT_WIDTH-1:0] v
  );
    return (&v) ? v : DROP_CNT_WIDTH'(v + 1'b1);
  endfunction

  logic [TS_WIDTH-1:0]   ts;
  logic [DATA_WIDTH-1:0] prev;
  logic                  primed;
  logic                  evt;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic                  accept;
  logic                  drop;
  rec_t                  rec_in;
  rec_t                  rec_out;

  // A record is taken when there is room, or when the head leaves this same cycle.
  assign evt       = enable && (!primed || (data != prev));
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign accept    = evt && (!full || pop);
  assign drop      = evt && !accept;
  assign rec_in    = '{ts: ts, data: data};
  assign out_ts    = rec_out.ts;
  assign out_data  = rec_out.data;

  always_ff @(posedge clock) begin
    if (clear) begin
      ts     <= '0;
      prev   <= '0;
      primed <= 1'b0;
    end else if (enable) begin
      ts     <= ts + 1'b1;
      prev   <= data;
      primed <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      overflow <= 1'b0;
      dropped  <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      dropped  <= sat_inc(dropped);
    end
  end

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .clear (clear),
    .push  (accept),
    .din   (rec_in),
    .full  (full),
    .pop   (pop),
    .dout  (rec_out),
    .empty (empty),
    .level (level)
  );

  // empty mirrors level==0; kept on the port list of the FIFO for other users.
  logic unused_empty;
  assign unused_empty = empty;

endmodule
